systolic_vector_ctrl: RTL

Sequencer for the weight-stationary `systolic_vector` array. It loads ROW weights into the array with `ctrl` high, then streams a job of feature vectors with per-row input skew. It tags each issued vector so the matching `vec_out` sample is captured and forwarded downstream. It sits between the weight/feature buffers and one `systolic_vector` instance.

---
 rtl/systolic_vector_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_vector_ctrl.sv
// Sequencer for a weight-stationary systolic_vector array.
// Loads weights, streams skewed feature vectors and captures tagged results.
module systolic_vector_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 2,
    parameter int MAX_LEN = 16,
    parameter int OUT_LAT = 2
) (
    input  logic                          clk_in1,
    input  logic                          rst_in1,
    input  logic                          start_in,
    input  logic [$clog2(MAX_LEN+1)-1:0]  vec_len_in,
    input  logic                          w_valid_in,
    output logic                          w_ready_out,
    input  logic [WIDTH-1:0]              w_data_in,
    input  logic                          f_valid_in,
    output logic                          f_ready_out,
    input  logic [WIDTH*ROW-1:0]          f_data_in,
    output logic                          arr_nrst_out,
    output logic                          arr_ctrl_out,
    output logic [WIDTH-1:0]              arr_weight_out,
    output logic [ROW-1:0][WIDTH-1:0]     arr_feature_out,
    input  logic [WIDTH-1:0]              arr_vec_in,
    output logic [WIDTH-1:0]              result_out,
    output logic                          result_valid_out,
    output logic                          busy_out,
    output logic                          done_out
);

    localparam int LW  = $clog2(MAX_LEN+1);
    localparam int D   = OUT_LAT + ROW;
    localparam int WCW = $clog2(ROW+1);
    localparam logic [WCW-1:0] W_LAST = WCW'(ROW-1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [LW-1:0]  len_q;
    logic [WCW-1:0] wcnt;
    logic [LW-1:0]  fcnt;
    logic [LW-1:0]  rcnt;
    logic [D-1:0]   tag;

    logic w_acc;
    logic f_acc;

    logic w_ready_d;
    logic f_ready_d;
    logic nrst_d;
    logic busy_d;
    logic done_d;

    assign w_acc = w_valid_in & w_ready_out;
    assign f_acc = f_valid_in & f_ready_out;

    // State register
    always_ff @(posedge clk_in1) begin
        if (rst_in1) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_in) next_state = LOAD_W;
            end
            LOAD_W: begin
                if (w_acc && wcnt == W_LAST)
                    next_state = (len_q == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (f_acc && fcnt == len_q - LW'(1))
                    next_state = DRAIN;
            end
            DRAIN: begin
                if (tag == '0 && rcnt == len_q)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        w_ready_d = 1'b0;
        f_ready_d = 1'b0;
        nrst_d    = 1'b0;
        case (next_state)
            LOAD_W: begin
                w_ready_d = 1'b1;
                nrst_d    = 1'b1;
            end
            STREAM: begin
                f_ready_d = 1'b1;
                nrst_d    = 1'b1;
            end
            DRAIN: begin
                nrst_d = 1'b1;
            end
            default: ;
        endcase
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
    end

    // Registered control outputs
    always_ff @(posedge clk_in1) begin
        if (rst_in1) begin
            w_ready_out  <= 1'b0;
            f_ready_out  <= 1'b0;
            arr_nrst_out <= 1'b0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            w_ready_out  <= w_ready_d;
            f_ready_out  <= f_ready_d;
            arr_nrst_out <= nrst_d;
            busy_out     <= busy_d;
            done_out     <= done_d;
        end
    end

    // Job counters, weight drive, tag pipe and result capture
    always_ff @(posedge clk_in1) begin
        if (rst_in1) begin
            len_q            <= '0;
            wcnt             <= '0;
            fcnt             <= '0;
            rcnt             <= '0;
            tag              <= '0;
            arr_ctrl_out     <= 1'b0;
            arr_weight_out   <= '0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
        end else begin
            if (state == IDLE && start_in) begin
                len_q <= vec_len_in;
                wcnt  <= '0;
                fcnt  <= '0;
                rcnt  <= '0;
            end else begin
                if (w_acc)      wcnt <= wcnt + WCW'(1);
                if (f_acc)      fcnt <= fcnt + LW'(1);
                if (tag[D-1])   rcnt <= rcnt + LW'(1);
            end
            arr_ctrl_out     <= w_acc;
            arr_weight_out   <= w_acc ? w_data_in : '0;
            tag              <= {tag[D-2:0], f_acc};
            result_valid_out <= tag[D-1];
            if (tag[D-1]) result_out <= arr_vec_in;
        end
    end

    // Per-row skew line: row r holds r+1 flops, bubbles enter as zero
    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [WIDTH-1:0] pipe [0:r];

        // Shift the row's feature toward the array
        always_ff @(posedge clk_in1) begin
            if (rst_in1) begin
                for (int k = 0; k <= r; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= f_acc ? f_data_in[r*WIDTH +: WIDTH] : '0;
                for (int k = 1; k <= r; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign arr_feature_out[r] = pipe[r];
    end

endmodule
